// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, fetch exception
// causes, FSM state encoding and the fetch-entry metadata layout.
// Pure declarations; no logic, no latency, no flow control.
package if_pkg;

    localparam logic [31:0] RV_NOP               = 32'h0000_0013;
    localparam logic [3:0]  EXC_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0]  EXC_INSTR_ACCESS     = 4'd1;

    typedef enum logic {
        IF_RUN  = 1'b0,
        IF_HALT = 1'b1
    } if_state_t;

    // XLEN-independent middle of a fetch entry; the full entry is {pc, meta, exc_val}.
    typedef struct packed {
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  exc_code;
    } fe_meta_t;

    localparam int FE_META_W = $bits(fe_meta_t);

    function automatic int fe_width(input int xlen);
        return 2 * xlen + FE_META_W;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched entries between imem and decode.
// Latency: an entry pushed in cycle N is on head_dat in cycle N+1 (head read from storage flops).
// Backpressure: push is ignored when full unless a pop happens the same cycle; flush beats push.
// Ports: push/push_dat write side, pop read side, flush empties, head_vld/head_dat/count status.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       head_vld,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop & (cnt != '0);
    assign do_push = push & ((cnt != CW'(DEPTH)) | do_pop);

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: head_vld gates every consumer of head_dat.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_vld = (cnt != '0);
    assign head_dat = mem[rd_ptr];
    assign count    = cnt;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, captures imem's same-cycle response into a fetch queue for decode.
// Latency: instruction fetched in cycle N is presented on id_* in cycle N+1.
// Backpressure: id_ready low holds head stable; PC and fetch freeze once the queue is full.
// Ports: redirect_en/redirect_pc in; pc_addr out to imem; imem_* in; id_* valid/ready to decode.
// Optional: define IF_PERF_CNT_EN to add perf_fetch_cnt / perf_stall_cnt outputs.
module if_stage
    import if_pkg::*;
#(
    parameter int               XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               Q_DEPTH  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc_addr,
    input  logic [31:0]     imem_instr,
    input  logic            imem_exc_en,
    input  logic [3:0]      imem_exc_code,
    input  logic [XLEN-1:0] imem_exc_val,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic            id_exc_en,
    output logic [3:0]      id_exc_code,
    output logic [XLEN-1:0] id_exc_val
`ifdef IF_PERF_CNT_EN
    ,
    output logic [63:0]     perf_fetch_cnt,
    output logic [63:0]     perf_stall_cnt
`endif
);

    localparam int EW = fe_width(XLEN);
    localparam int CW = $clog2(Q_DEPTH + 1);

    if_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   q_count;
    logic            head_vld;
    logic [EW-1:0]   head_dat;
    logic [EW-1:0]   enq_dat;
    fe_meta_t        enq_meta;
    logic [XLEN-1:0] enq_val;
    fe_meta_t        head_meta;
    logic            misaligned;
    logic            deq;
    logic            enq;

    // pc+4 keeps alignment, so a misaligned pc_q can only come from a redirect target
    // (or a misaligned RESET_PC); it is reported without consulting imem.
    assign misaligned = (pc_q[1:0] != 2'b00);

    assign deq = head_vld & id_ready;
    assign enq = (state_q == IF_RUN) & ~redirect_en & ((q_count != CW'(Q_DEPTH)) | deq);

    always_comb begin
        enq_meta.instr    = imem_instr;
        enq_meta.exc_en   = imem_exc_en;
        enq_meta.exc_code = imem_exc_code;
        enq_val           = imem_exc_val;
        if (misaligned) begin
            enq_meta.exc_en   = 1'b1;
            enq_meta.exc_code = EXC_INSTR_MISALIGNED;
            enq_val           = pc_q;
        end
        if (enq_meta.exc_en) enq_meta.instr = RV_NOP;
    end

    assign enq_dat = {pc_q, enq_meta, enq_val};

    // FSM and PC: redirect overrides everything; an exception entry parks the PC
    // so the faulting address is never fetched twice.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_en) begin
            state_d = IF_RUN;
            pc_d    = redirect_pc;
        end else if (enq) begin
            if (enq_meta.exc_en) state_d = IF_HALT;
            else                 pc_d    = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IF_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (Q_DEPTH),
        .W     (EW)
    ) u_fetch_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (enq),
        .push_dat (enq_dat),
        .pop      (deq),
        .flush    (redirect_en),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .count    (q_count)
    );

    assign head_meta = head_dat[XLEN +: FE_META_W];

    // Empty queue presents a NOP with all other fields zero.
    assign pc_addr     = pc_q;
    assign id_valid    = head_vld;
    assign id_pc       = head_vld ? head_dat[EW-1 -: XLEN] : '0;
    assign id_instr    = head_vld ? head_meta.instr : RV_NOP;
    assign id_exc_en   = head_vld & head_meta.exc_en;
    assign id_exc_code = head_vld ? head_meta.exc_code : 4'd0;
    assign id_exc_val  = head_vld ? head_dat[XLEN-1:0] : '0;

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (enq) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if ((state_q == IF_RUN) && !enq && !redirect_en)
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
        end
    end
`endif

endmodule
